// File: rtl/ex_branch_resolve_feedback.sv
// EX-side branch resolution: checks in-order IF predictions against EX
// outcomes, trains the BHT, and redirects/flushes on a mispredict.
// Ports: clk, reset (async, active-high)
//   in : if_push/if_pc/if_pred_take/if_pred_target (IF prediction)
//        ex_resolve/ex_taken/ex_target (oldest branch outcome)
//   out: pc_jmp_feedback/pc_jmp_take/pc_stash_base (BHT training)
//        redirect_valid/redirect_pc, flush, full, resolve_err
// Optional: BRANCH_STATS_EN adds stat_resolved/stat_mispredict counters.
module ex_branch_resolve_feedback #(
    parameter int DEPTH        = 4,
    parameter int PTR_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_push,
    input  logic [31:0] if_pc,
    input  logic        if_pred_take,
    input  logic [31:0] if_pred_target,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        pc_jmp_feedback,
    output logic        pc_jmp_take,
    output logic [31:0] pc_stash_base,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        full,
    output logic        resolve_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict
`endif
);

    typedef enum logic {
        ST_RUN,
        ST_RECOVER
    } state_e;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0]     RC_LOAD  = 4'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [3:0]        rc_q, rc_d;
    logic [31:0]       mem_pc_q [DEPTH];
    logic [31:0]       mem_pc_d [DEPTH];
    logic              mem_tk_q [DEPTH];
    logic              mem_tk_d [DEPTH];
    logic [31:0]       mem_tg_q [DEPTH];
    logic [31:0]       mem_tg_d [DEPTH];
    logic              fb_q, fb_d;
    logic              take_q, take_d;
    logic [31:0]       base_q, base_d;
    logic              rv_q, rv_d;
    logic [31:0]       rpc_q, rpc_d;
    logic              flush_q, flush_d;
    logic              err_q, err_d;
`ifdef BRANCH_STATS_EN
    logic [31:0]       sres_q, sres_d;
    logic [31:0]       smis_q, smis_d;
`endif

    logic              full_w;
    logic              resolve;
    logic              mispredict;
    logic              push_ok;
    logic [31:0]       head_pc;
    logic              head_tk;
    logic [31:0]       head_tg;

    assign full_w  = (count_q == FULL_CNT);
    assign head_pc = mem_pc_q[rd_ptr_q];
    assign head_tk = mem_tk_q[rd_ptr_q];
    assign head_tg = mem_tg_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        rc_d       = rc_q;
        mem_pc_d   = mem_pc_q;
        mem_tk_d   = mem_tk_q;
        mem_tg_d   = mem_tg_q;
        fb_d       = 1'b0;
        take_d     = take_q;
        base_d     = base_q;
        rv_d       = 1'b0;
        rpc_d      = rpc_q;
        flush_d    = flush_q;
        err_d      = 1'b0;
        resolve    = 1'b0;
        mispredict = 1'b0;
        push_ok    = 1'b0;
`ifdef BRANCH_STATS_EN
        sres_d     = sres_q;
        smis_d     = smis_q;
`endif
        unique case (state_q)
            ST_RUN: begin
                resolve    = ex_resolve && (count_q != '0);
                mispredict = resolve &&
                             ((ex_taken != head_tk) ||
                              (ex_taken && (ex_target != head_tg)));
                err_d      = ex_resolve && (count_q == '0);
                if (resolve) begin
                    fb_d   = 1'b1;
                    take_d = ex_taken;
                    base_d = head_pc;
`ifdef BRANCH_STATS_EN
                    if (sres_q != '1) sres_d = sres_q + 32'd1;
`endif
                end
                if (mispredict) begin
                    // Younger entries and any same-cycle push are wrong-path.
                    rv_d     = 1'b1;
                    rpc_d    = ex_taken ? ex_target : head_pc + 32'd4;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    state_d  = ST_RECOVER;
                    flush_d  = 1'b1;
                    rc_d     = RC_LOAD;
`ifdef BRANCH_STATS_EN
                    if (smis_q != '1) smis_d = smis_q + 32'd1;
`endif
                end else begin
                    // A correct resolve frees the head slot this cycle.
                    push_ok = if_push && (!full_w || resolve);
                    if (push_ok) begin
                        mem_pc_d[wr_ptr_q] = if_pc;
                        mem_tk_d[wr_ptr_q] = if_pred_take;
                        mem_tg_d[wr_ptr_q] = if_pred_target;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                    if (resolve) rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (push_ok && !resolve) begin
                        count_d = count_q + (PTR_W + 1)'(1);
                    end else if (!push_ok && resolve) begin
                        count_d = count_q - (PTR_W + 1)'(1);
                    end
                end
            end
            ST_RECOVER: begin
                if (rc_q == '0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    rc_d = rc_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rc_q     <= '0;
            mem_pc_q <= '{default: '0};
            mem_tk_q <= '{default: '0};
            mem_tg_q <= '{default: '0};
            fb_q     <= 1'b0;
            take_q   <= 1'b0;
            base_q   <= '0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            flush_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef BRANCH_STATS_EN
            sres_q   <= '0;
            smis_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rc_q     <= rc_d;
            mem_pc_q <= mem_pc_d;
            mem_tk_q <= mem_tk_d;
            mem_tg_q <= mem_tg_d;
            fb_q     <= fb_d;
            take_q   <= take_d;
            base_q   <= base_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
            flush_q  <= flush_d;
            err_q    <= err_d;
`ifdef BRANCH_STATS_EN
            sres_q   <= sres_d;
            smis_q   <= smis_d;
`endif
        end
    end

    assign pc_jmp_feedback = fb_q;
    assign pc_jmp_take     = take_q;
    assign pc_stash_base   = base_q;
    assign redirect_valid  = rv_q;
    assign redirect_pc     = rpc_q;
    assign flush           = flush_q;
    assign full            = full_w;
    assign resolve_err     = err_q;
`ifdef BRANCH_STATS_EN
    assign stat_resolved   = sres_q;
    assign stat_mispredict = smis_q;
`endif

endmodule

// File: tb/tb_ex_branch_resolve_feedback.sv
// Bench for ex_branch_resolve_feedback: directed scenarios plus random
// traffic, all checked against a queue-based model of the resolver.
module tb_ex_branch_resolve_feedback;

    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_push = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_pred_take = 1'b0;
    logic [31:0] if_pred_target = '0;
    logic        ex_resolve = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        pc_jmp_feedback;
    logic        pc_jmp_take;
    logic [31:0] pc_stash_base;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        full;
    logic        resolve_err;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;
`endif

    always #5 clk = ~clk;

    ex_branch_resolve_feedback #(
        .DEPTH(DEPTH), .PTR_W(2), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_push(if_push),
        .if_pc(if_pc),
        .if_pred_take(if_pred_take),
        .if_pred_target(if_pred_target),
        .ex_resolve(ex_resolve),
        .ex_taken(ex_taken),
        .ex_target(ex_target),
        .pc_jmp_feedback(pc_jmp_feedback),
        .pc_jmp_take(pc_jmp_take),
        .pc_stash_base(pc_stash_base),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .flush(flush),
        .full(full),
        .resolve_err(resolve_err)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved(stat_resolved),
        .stat_mispredict(stat_mispredict)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
    } ent_t;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Model: in-flight predictions as a queue, recovery as cycles left.
    ent_t        mq[$];
    ent_t        h;
    int          left = 0;
    bit          e_fb = 0, e_tk = 0, e_rv = 0, e_fl = 0, e_err = 0;
    logic [31:0] e_base = '0, e_rpc = '0;
    logic [31:0] e_sr = '0, e_sm = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            left = 0;
            e_fb = 0; e_tk = 0; e_rv = 0; e_fl = 0; e_err = 0;
            e_base = '0; e_rpc = '0; e_sr = '0; e_sm = '0;
        end else begin
            e_fb = 0; e_rv = 0; e_err = 0;
            if (left > 0) begin
                left--;
                e_fl = (left > 0);
            end else if (ex_resolve && mq.size() == 0) begin
                e_err = 1;
                if (if_push) mq.push_back({if_pc, if_pred_take, if_pred_target});
            end else if (ex_resolve) begin
                h = mq.pop_front();
                e_fb = 1;
                e_tk = ex_taken;
                e_base = h.pc;
                if (e_sr != 32'hFFFF_FFFF) e_sr = e_sr + 1;
                if (ex_taken != h.tk || (ex_taken && ex_target != h.tg)) begin
                    e_rv = 1;
                    e_rpc = ex_taken ? ex_target : h.pc + 32'd4;
                    mq.delete();
                    left = FC;
                    e_fl = 1;
                    if (e_sm != 32'hFFFF_FFFF) e_sm = e_sm + 1;
                end else if (if_push) begin
                    mq.push_back({if_pc, if_pred_take, if_pred_target});
                end
            end else if (if_push && mq.size() < DEPTH) begin
                mq.push_back({if_pc, if_pred_take, if_pred_target});
            end
        end
    end

    always @(negedge clk) begin
        chk("m_feedback", 32'(pc_jmp_feedback), 32'(e_fb));
        chk("m_redirect", 32'(redirect_valid), 32'(e_rv));
        chk("m_flush", 32'(flush), 32'(e_fl));
        chk("m_err", 32'(resolve_err), 32'(e_err));
        chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
        if (e_fb) begin
            chk("m_take", 32'(pc_jmp_take), 32'(e_tk));
            chk("m_base", pc_stash_base, e_base);
        end
        if (e_rv) chk("m_rpc", redirect_pc, e_rpc);
`ifdef BRANCH_STATS_EN
        chk("m_sres", stat_resolved, e_sr);
        chk("m_smis", stat_mispredict, e_sm);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_push = 0; if_pc = '0; if_pred_take = 0; if_pred_target = '0;
        ex_resolve = 0; ex_taken = 0; ex_target = '0;
    endtask

    task automatic set_push(logic [31:0] pc, logic tk, logic [31:0] tg);
        if_push = 1; if_pc = pc; if_pred_take = tk; if_pred_target = tg;
    endtask

    task automatic set_res(logic tk, logic [31:0] tg);
        ex_resolve = 1; ex_taken = tk; ex_target = tg;
    endtask

    logic [31:0] exp_pcs [4];

    initial begin
        idle();
        reset = 1;
        repeat (3) tick();
        chk("rst_fb", 32'(pc_jmp_feedback), 0);
        chk("rst_take", 32'(pc_jmp_take), 0);
        chk("rst_base", pc_stash_base, 0);
        chk("rst_rv", 32'(redirect_valid), 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(resolve_err), 0);
        reset = 0;
        tick();

        // Correct taken prediction
        set_push(32'h100, 1, 32'h200); tick(); idle();
        set_res(1, 32'h200); tick(); idle();
        chk("t1_fb", 32'(pc_jmp_feedback), 1);
        chk("t1_take", 32'(pc_jmp_take), 1);
        chk("t1_base", pc_stash_base, 32'h100);
        chk("t1_rv", 32'(redirect_valid), 0);
        chk("t1_flush", 32'(flush), 0);
        tick();
        chk("t1_fb_off", 32'(pc_jmp_feedback), 0);

        // Direction miss
        set_push(32'h104, 1, 32'h300); tick(); idle();
        set_res(0, 32'h0); tick(); idle();
        chk("t2_rv", 32'(redirect_valid), 1);
        chk("t2_rpc", redirect_pc, 32'h108);
        chk("t2_flush", 32'(flush), 1);
        chk("t2_fb", 32'(pc_jmp_feedback), 1);
        chk("t2_take", 32'(pc_jmp_take), 0);
        chk("t2_base", pc_stash_base, 32'h104);
        tick();
        chk("t2_rv_off", 32'(redirect_valid), 0);
        chk("t2_flush2", 32'(flush), 1);
        tick();
        chk("t2_flush3", 32'(flush), 0);

        // Target miss, then resolves during recovery are ignored
        set_push(32'h40, 1, 32'h80); tick(); idle();
        set_res(1, 32'h90); tick();
        chk("t3_rv", 32'(redirect_valid), 1);
        chk("t3_rpc", redirect_pc, 32'h90);
        chk("t3_take", 32'(pc_jmp_take), 1);
        tick();
        chk("t5_rec_fb", 32'(pc_jmp_feedback), 0);
        chk("t5_rec_err", 32'(resolve_err), 0);
        tick();
        chk("t5_rec_fb2", 32'(pc_jmp_feedback), 0);
        chk("t5_rec_err2", 32'(resolve_err), 0);
        chk("t5_rec_fl", 32'(flush), 0);
        idle();

        // Resolve with empty queue
        set_res(1, 32'h0); tick(); idle();
        chk("t5_err", 32'(resolve_err), 1);
        chk("t5_err_fb", 32'(pc_jmp_feedback), 0);
        tick();
        chk("t5_err_off", 32'(resolve_err), 0);

        // Fill, drop, push+resolve across pointer wrap
        for (int i = 0; i < 4; i++) begin
            set_push(32'h1000 + 32'(16 * i), 0, 32'h0); tick();
        end
        chk("t4_full", 32'(full), 1);
        set_push(32'h2000, 0, 32'h0); tick();
        chk("t4_full_drop", 32'(full), 1);
        set_push(32'h3000, 0, 32'h0); set_res(0, 32'h0); tick(); idle();
        chk("t4_pr_fb", 32'(pc_jmp_feedback), 1);
        chk("t4_pr_base", pc_stash_base, 32'h1000);
        chk("t4_pr_full", 32'(full), 1);
        exp_pcs[0] = 32'h1010; exp_pcs[1] = 32'h1020;
        exp_pcs[2] = 32'h1030; exp_pcs[3] = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            set_res(0, 32'h0); tick();
            chk("t4_order", pc_stash_base, exp_pcs[i]);
        end
        idle();
        chk("t4_empty", 32'(full), 0);
        tick();

        // Reset with queued entries
        for (int i = 0; i < 3; i++) begin
            set_push(32'h500 + 32'(4 * i), 1, 32'h600); tick();
        end
        idle();
        reset = 1; #2;
        chk("t6_full", 32'(full), 0);
        chk("t6_flush", 32'(flush), 0);
        tick();
        reset = 0;
        tick();

        // Reset in the middle of recovery
        for (int i = 0; i < 4; i++) begin
            set_push(32'h700 + 32'(4 * i), 0, 32'h0); tick();
        end
        idle();
        set_res(1, 32'h900); tick(); idle();
        chk("t6_rec_flush", 32'(flush), 1);
        reset = 1; #2;
        chk("t6_rst_flush", 32'(flush), 0);
        chk("t6_rst_full", 32'(full), 0);
        chk("t6_rst_rv", 32'(redirect_valid), 0);
`ifdef BRANCH_STATS_EN
        chk("t6_rst_sres", stat_resolved, 0);
        chk("t6_rst_smis", stat_mispredict, 0);
`endif
        tick();
        reset = 0;
        tick();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            idle();
            if ($urandom_range(0, 99) < 55) begin
                set_push({20'h0, 10'($urandom), 2'b00},
                         1'($urandom),
                         {26'h0, 2'($urandom), 4'h0});
            end
            if ($urandom_range(0, 99) < 40) begin
                set_res(($urandom_range(0, 99) < 50),
                        {26'h0, 2'($urandom), 4'h0});
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1; #2;
                tick();
                reset = 0;
            end else begin
                tick();
            end
        end
        idle();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
